// File: rtl/duty_pkg.sv
// Shared types and constants for the duty-cycle measurement sequencer.
package duty_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        DISCARD = 3'd2,
        ACC     = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_TO  = 2'd1;
    localparam logic [1:0] ERR_BAD = 2'd2;

    localparam int T_MIN_DEF   = 20;
    localparam int TIMEOUT_DEF = 2000;

endpackage

// File: rtl/meas_timeout.sv
// Watchdog counter: runs while the core should be producing results and is
// kicked back to zero by every core result.
module meas_timeout
    import duty_pkg::*;
#(
    parameter int TO_W    = 12,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic c0,
    input  logic rst_n,
    input  logic run,
    input  logic kick,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

    logic [TO_W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge c0) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || kick) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/duty_meas_ctrl.sv
// Sequencer for the duty-cycle measurement core: arm, drop the partial first
// period, average N periods and hand one record to the readout side.
module duty_meas_ctrl
    import duty_pkg::*;
#(
    parameter int W       = 10,
    parameter int LOG2N   = 3,
    parameter int TO_W    = 12,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int T_MIN   = T_MIN_DEF
) (
    input  logic         c0,
    input  logic         rst_n,
    input  logic         start,
    input  logic         cont,
    output logic         core_clr,
    output logic         core_en,
    input  logic         core_valid,
    input  logic [W-1:0] core_th,
    input  logic [W-1:0] core_t,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_th,
    output logic [W-1:0] res_t,
    output logic [1:0]   res_err,
    output logic         busy
);

    localparam int             SW    = W + LOG2N;
    localparam logic [LOG2N:0] LAST  = (LOG2N+1)'((1 << LOG2N) - 1);
    localparam logic [W-1:0]   T_LIM = W'(T_MIN);

    state_t          state, state_nxt;
    logic [SW-1:0]   sum_th, sum_t, sum_th_nxt, sum_t_nxt;
    logic [LOG2N:0]  n_cnt;
    logic            bad, bad_nxt, sample_bad;
    logic            take, to_hit, done_entry;
    logic            run, expired;

    assign run = (state == DISCARD) || (state == ACC);

    meas_timeout #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .c0      (c0),
        .rst_n   (rst_n),
        .run     (run),
        .kick    (core_valid),
        .expired (expired)
    );

    assign sample_bad = (core_th >= core_t) || (core_t < T_LIM);
    assign bad_nxt    = bad | sample_bad;
    assign sum_th_nxt = sum_th + SW'(core_th);
    assign sum_t_nxt  = sum_t + SW'(core_t);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        to_hit    = 1'b0;
        unique case (state)
            IDLE:    if (start) state_nxt = ARM;
            ARM:     state_nxt = DISCARD;
            DISCARD: begin
                if (expired) begin
                    to_hit    = 1'b1;
                    state_nxt = DONE;
                end else if (core_valid) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                // Timeout wins over a sample that would complete the record.
                if (expired) begin
                    to_hit    = 1'b1;
                    state_nxt = DONE;
                end else if (core_valid) begin
                    take = 1'b1;
                    if (n_cnt == LAST) state_nxt = DONE;
                end
            end
            DONE:    if (res_ready) state_nxt = cont ? ARM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign done_entry = (state != DONE) && (state_nxt == DONE);

    always_ff @(posedge c0) begin
        if (!rst_n) begin
            state     <= IDLE;
            sum_th    <= '0;
            sum_t     <= '0;
            n_cnt     <= '0;
            bad       <= 1'b0;
            res_valid <= 1'b0;
            res_th    <= '0;
            res_t     <= '0;
            res_err   <= ERR_OK;
        end else begin
            state <= state_nxt;

            if (state == ARM) begin
                sum_th <= '0;
                sum_t  <= '0;
                n_cnt  <= '0;
                bad    <= 1'b0;
            end else if (take) begin
                sum_th <= sum_th_nxt;
                sum_t  <= sum_t_nxt;
                n_cnt  <= n_cnt + 1'b1;
                bad    <= bad_nxt;
            end

            // The record is built from the "next" sums so the Nth sample is
            // included without an extra cycle of latency.
            if (done_entry) begin
                res_valid <= 1'b1;
                if (to_hit) begin
                    res_th  <= '0;
                    res_t   <= '0;
                    res_err <= ERR_TO;
                end else begin
                    res_th  <= W'(sum_th_nxt >> LOG2N);
                    res_t   <= W'(sum_t_nxt >> LOG2N);
                    res_err <= bad_nxt ? ERR_BAD : ERR_OK;
                end
            end else if ((state == DONE) && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign core_clr = (state == ARM);
    assign core_en  = run;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_duty_meas_ctrl.sv
// Randomized self-checking bench for duty_meas_ctrl against an averaging model.
module tb_duty_meas_ctrl;

    localparam int N     = 8;
    localparam int T_MIN = 20;

    logic       c0 = 1'b0;
    logic       rst_n, start, cont, core_valid, res_ready;
    logic [9:0] core_th, core_t;
    logic       core_clr, core_en, res_valid, busy;
    logic [9:0] res_th, res_t;
    logic [1:0] res_err;

    int n_checks = 0;
    int n_fail   = 0;

    int q_th[$];
    int q_t[$];
    int e_th, e_t, e_err;
    bit chained;

    duty_meas_ctrl dut (
        .c0         (c0),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .core_clr   (core_clr),
        .core_en    (core_en),
        .core_valid (core_valid),
        .core_th    (core_th),
        .core_t     (core_t),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_th     (res_th),
        .res_t      (res_t),
        .res_err    (res_err),
        .busy       (busy)
    );

    always #5 c0 = ~c0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge c0);
        #1;
    endtask

    // Reference: plain mean of the N accepted samples, error if any is implausible.
    task automatic build_expect();
        int s_th = 0;
        int s_t  = 0;
        bit b    = 0;
        for (int i = 0; i < N; i++) begin
            s_th += q_th[i];
            s_t  += q_t[i];
            if (q_th[i] >= q_t[i] || q_t[i] < T_MIN) b = 1;
        end
        e_th  = s_th / N;
        e_t   = s_t / N;
        e_err = b ? 2 : 0;
    endtask

    task automatic fill_good();
        q_th.delete();
        q_t.delete();
        for (int i = 0; i < N; i++) begin
            int t = $urandom_range(T_MIN, 1023);
            q_t.push_back(t);
            q_th.push_back($urandom_range(0, t - 1));
        end
    endtask

    task automatic do_sample(input int th, input int t);
        core_th    = 10'(th);
        core_t     = 10'(t);
        core_valid = 1'b1;
        tick();
        core_valid = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) tick();
    endtask

    // Runs one record from ARM (optionally issuing start first) up to res_valid.
    task automatic measure(input bit do_start, input bit arm_noise);
        build_expect();
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("arm_clr", core_clr, 1);
        check("arm_en", core_en, 0);
        if (arm_noise) do_sample(7, 9);
        else tick();
        check("disc_en", core_en, 1);
        gap();
        do_sample($urandom_range(0, 1023), $urandom_range(0, 1023));
        for (int i = 0; i < N; i++) begin
            gap();
            check("early_valid", res_valid, 0);
            do_sample(q_th[i], q_t[i]);
        end
        check("lat_valid", res_valid, 1);
        check("res_th", res_th, e_th);
        check("res_t", res_t, e_t);
        check("res_err", res_err, e_err);
        check("done_en", core_en, 0);
    endtask

    // Holds the record for a while (with a stray start), then accepts it.
    task automatic accept(input int hold, input bit c);
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start = (i == 1);
            tick();
            check("hold_valid", res_valid, 1);
            check("hold_th", res_th, e_th);
            check("hold_t", res_t, e_t);
            check("hold_err", res_err, e_err);
            check("hold_busy", busy, 1);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        cont      = c;
        tick();
        res_ready = 1'b0;
        cont      = 1'b0;
        check("acc_drop", res_valid, 0);
        if (c) begin
            check("cont_clr", core_clr, 1);
        end else begin
            check("idle_busy", busy, 0);
            tick();
            check("no_queue", busy, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; core_valid = 1'b0;
        res_ready = 1'b0; core_th = '0; core_t = '0;
        repeat (3) tick();
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_clr", core_clr, 0);
        check("rst_en", core_en, 0);
        check("rst_th", res_th, 0);
        check("rst_err", res_err, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy0", busy, 0);

        // Constant 50 % duty.
        q_th = {250, 250, 250, 250, 250, 250, 250, 250};
        q_t  = {500, 500, 500, 500, 500, 500, 500, 500};
        measure(1, 0);
        accept(3, 0);

        // Truncating average: 828 / 8 = 103.
        q_th = {100, 101, 102, 103, 104, 105, 106, 107};
        q_t  = {200, 200, 200, 200, 200, 200, 200, 200};
        measure(1, 0);
        check("trunc_th", res_th, 103);
        accept(2, 0);

        // No core activity at all.
        begin
            int cyc = 0;
            start = 1'b1;
            tick();
            start = 1'b0;
            while (!res_valid && cyc < 2100) begin
                tick();
                cyc++;
            end
            check("to_seen", res_valid, 1);
            check("to_window", (cyc >= 1995 && cyc <= 2010), 1);
            e_th = 0; e_t = 0; e_err = 1;
            check("to_err", res_err, 1);
            check("to_th", res_th, 0);
            check("to_t", res_t, 0);
            accept(5, 0);
        end

        // High time not below period.
        fill_good();
        begin
            int p = $urandom_range(0, N - 1);
            q_th[p] = 500;
            q_t[p]  = 400;
        end
        measure(1, 0);
        check("bad_hi", res_err, 2);
        accept(1, 0);

        // Period shorter than the legal minimum.
        fill_good();
        q_th[3] = 5;
        q_t[3]  = 15;
        measure(1, 0);
        check("bad_short", res_err, 2);
        accept(1, 0);

        // Long hold, then continuous re-arm with a core_valid during ARM.
        fill_good();
        measure(1, 0);
        accept(50, 1);
        fill_good();
        measure(0, 1);
        accept(2, 0);

        // Reset mid-accumulation, then a clean record.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) do_sample(900, 950);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_en", core_en, 0);
        check("mid_rst_clr", core_clr, 0);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_th", res_th, 0);
        check("mid_rst_t", res_t, 0);
        check("mid_rst_err", res_err, 0);
        fill_good();
        measure(1, 0);
        accept(1, 0);

        // Random records, occasionally implausible, randomly chained.
        chained = 0;
        for (int r = 0; r < 8; r++) begin
            bit c = ($urandom_range(0, 1) == 1);
            fill_good();
            if ($urandom_range(0, 3) == 0) begin
                int p = $urandom_range(0, N - 1);
                q_t[p] = $urandom_range(1, 1023);
                q_th[p] = $urandom_range(0, 1023);
            end
            measure(!chained, chained && ($urandom_range(0, 1) == 1));
            accept($urandom_range(0, 4), c);
            chained = c;
        end
        if (chained) begin
            fill_good();
            measure(0, 0);
            accept(0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
